// File: rtl/conversor_teclado_ascii_fifo.sv
// Key-code to ASCII converter feeding a first-word-fall-through character buffer.
// Optional repeat filter is built only when KEY_REPEAT_FILTER_EN is defined.
module conversor_teclado_ascii_fifo #(
    parameter int KEY_W      = 4,
    parameter int DEPTH      = 8,
    parameter int LOWERCASE  = 0,
    parameter int REPEAT_GAP = 1000
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       tecla_valid,
    input  logic [KEY_W-1:0]           tecla_code,
    input  logic                       ascii_ready,
    output logic                       ascii_valid,
    output logic [7:0]                 ascii_data,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       full,
    output logic                       overflow,
    input  logic                       overflow_clr
);

    localparam int CNT_W = $clog2(DEPTH+1);
    localparam int PTR_W = $clog2(DEPTH);

    logic [7:0]       mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             overflow_q, overflow_d;
    logic             eligible_s, push_s, pop_s, drop_s;
    logic [7:0]       char_s;

    function automatic logic [7:0] map_code(input logic [KEY_W-1:0] code);
        logic [7:0] cw;
        cw = 8'(code);
        if (cw < 8'd10) begin
            return 8'h30 + cw;
        end else if (cw < 8'd16) begin
            return ((LOWERCASE != 0) ? 8'h61 : 8'h41) + (cw - 8'd10);
        end else begin
            return 8'h3F;
        end
    endfunction

`ifdef KEY_REPEAT_FILTER_EN
    localparam int GAP_W = $clog2(REPEAT_GAP+1);

    // gap_q counts cycles since the last accepted key; resetting it to REPEAT_GAP
    // makes the very first key always eligible.
    logic [GAP_W-1:0] gap_q, gap_d;
    logic [KEY_W-1:0] last_q, last_d;

    // Repeat decision from the registered filter state
    always_comb begin
        if ((tecla_code == last_q) && (gap_q < GAP_W'(REPEAT_GAP))) begin
            eligible_s = 1'b0;
        end else begin
            eligible_s = 1'b1;
        end
    end

    // Filter next state: restart on acceptance, otherwise saturating count
    always_comb begin
        last_d = last_q;
        gap_d  = gap_q;
        if (push_s) begin
            last_d = tecla_code;
            gap_d  = GAP_W'(1);
        end else if (gap_q < GAP_W'(REPEAT_GAP)) begin
            gap_d = gap_q + GAP_W'(1);
        end else begin
            gap_d = gap_q;
        end
    end

    // Filter state registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            gap_q  <= GAP_W'(REPEAT_GAP);
            last_q <= '0;
        end else begin
            gap_q  <= gap_d;
            last_q <= last_d;
        end
    end
`else
    assign eligible_s = 1'b1;
`endif

    // Handshake decode and next-state for pointers, count and overflow flag
    always_comb begin
        char_s     = map_code(tecla_code);
        pop_s      = (count_q != CNT_W'(0)) && ascii_ready;
        push_s     = tecla_valid && eligible_s &&
                     ((count_q != CNT_W'(DEPTH)) || pop_s);
        drop_s     = tecla_valid && eligible_s && !push_s;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        overflow_d = overflow_q;
        if (push_s) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (pop_s) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        case ({push_s, pop_s})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
        if (drop_s) begin
            overflow_d = 1'b1;
        end else if (overflow_clr) begin
            overflow_d = 1'b0;
        end else begin
            overflow_d = overflow_q;
        end
    end

    // Control state registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

    // Character storage; contents are masked at the output while empty
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_q[wr_ptr_q] <= char_s;
        end
    end

    assign ascii_valid = (count_q != CNT_W'(0));
    assign full        = (count_q == CNT_W'(DEPTH));
    assign count       = count_q;
    assign overflow    = overflow_q;
    assign ascii_data  = ascii_valid ? mem_q[rd_ptr_q] : 8'h00;

endmodule

// File: tb/tb_conversor_teclado_ascii_fifo.sv
// Bench for conversor_teclado_ascii_fifo: vector table, corner sequences and a
// randomized run against a queue-based model (repeat filter checked when enabled).
module tb_conversor_teclado_ascii_fifo;

    localparam int DEPTH = 8;
    localparam int GAP   = 10;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       tecla_valid = 1'b0;
    logic [4:0] tecla_code = 5'd0;
    logic       ascii_ready = 1'b0;
    logic       overflow_clr = 1'b0;
    logic       ascii_valid;
    logic [7:0] ascii_data;
    logic [3:0] count;
    logic       full;
    logic       overflow;

    logic       lc_tvalid = 1'b0;
    logic [4:0] lc_code = 5'd0;
    logic       lc_avalid;
    logic [7:0] lc_data;
    logic [2:0] lc_count;
    logic       lc_full;
    logic       lc_ovf;

    int checks = 0;
    int failures = 0;

    logic [7:0] mq[$];
    bit         m_ovf;
    int         cyc;
    int         last_acc;
    int         last_code;
    bit         have_last;

    always #5 clk = ~clk;

    conversor_teclado_ascii_fifo #(.KEY_W(5), .DEPTH(DEPTH), .LOWERCASE(0), .REPEAT_GAP(GAP)) dut (
        .clk(clk), .rst(rst), .tecla_valid(tecla_valid), .tecla_code(tecla_code),
        .ascii_ready(ascii_ready), .ascii_valid(ascii_valid), .ascii_data(ascii_data),
        .count(count), .full(full), .overflow(overflow), .overflow_clr(overflow_clr));

    conversor_teclado_ascii_fifo #(.KEY_W(5), .DEPTH(4), .LOWERCASE(1), .REPEAT_GAP(GAP)) u_lc (
        .clk(clk), .rst(rst), .tecla_valid(lc_tvalid), .tecla_code(lc_code),
        .ascii_ready(1'b1), .ascii_valid(lc_avalid), .ascii_data(lc_data),
        .count(lc_count), .full(lc_full), .overflow(lc_ovf), .overflow_clr(1'b0));

    typedef struct {
        logic [4:0] code;
        logic [7:0] exp;
    } vec_t;

    vec_t vecs[8];

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    function automatic logic [7:0] ref_char(input int code, input bit lower);
        if (code <= 9) return 8'(48 + code);
        else if (code <= 15) return 8'((lower ? 97 : 65) + code - 10);
        else return 8'h3F;
    endfunction

    task automatic model_reset();
        mq.delete();
        m_ovf     = 1'b0;
        have_last = 1'b0;
    endtask

    // One clock: compare DUT against the model, then advance both.
    task automatic cycle();
        bit pop, push, elig, nxt_ovf;
        chk("valid", ascii_valid, mq.size() != 0);
        if (mq.size() != 0) chk("data", ascii_data, mq[0]);
        chk("count", count, mq.size());
        chk("full", full, mq.size() == DEPTH);
        chk("overflow", overflow, m_ovf);
        pop  = (mq.size() != 0) && ascii_ready;
        elig = 1'b1;
`ifdef KEY_REPEAT_FILTER_EN
        if (have_last && (int'(tecla_code) == last_code) && ((cyc - last_acc) < GAP)) elig = 1'b0;
`endif
        push = tecla_valid && elig && ((mq.size() < DEPTH) || pop);
        if (tecla_valid && elig && !push) nxt_ovf = 1'b1;
        else if (overflow_clr) nxt_ovf = 1'b0;
        else nxt_ovf = m_ovf;
        @(posedge clk);
        if (pop) void'(mq.pop_front());
        if (push) begin
            mq.push_back(ref_char(int'(tecla_code), 1'b0));
            have_last = 1'b1;
            last_code = int'(tecla_code);
            last_acc  = cyc;
        end
        m_ovf = nxt_ovf;
        cyc++;
        @(negedge clk);
    endtask

    // Assert reset at a negedge, check outputs before any edge, release at next negedge.
    task automatic do_reset();
        rst = 1'b1;
        #1;
        chk("rst_valid", ascii_valid, 0);
        chk("rst_count", count, 0);
        chk("rst_full", full, 0);
        chk("rst_ovf", overflow, 0);
        chk("rst_data", ascii_data, 8'h00);
        model_reset();
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        logic [7:0] last_seen;
        int start;
        vecs[0] = '{5'd0,  8'h30};
        vecs[1] = '{5'd9,  8'h39};
        vecs[2] = '{5'd10, 8'h41};
        vecs[3] = '{5'd15, 8'h46};
        vecs[4] = '{5'd16, 8'h3F};
        vecs[5] = '{5'd31, 8'h3F};
        vecs[6] = '{5'd5,  8'h35};
        vecs[7] = '{5'd12, 8'h43};
        model_reset();
        cyc = 0;
        @(negedge clk);
        do_reset();

        // Back-to-back mapping vectors, each visible one cycle after its push
        ascii_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tecla_valid = 1'b1;
            tecla_code  = vecs[i].code;
            cycle();
            chk("vec_valid", ascii_valid, 1);
            chk("vec_data", ascii_data, vecs[i].exp);
        end
        tecla_valid = 1'b0;
        cycle();
        chk("vec_drained", ascii_valid, 0);

        // Lowercase instance
        lc_tvalid = 1'b1;
        lc_code   = 5'd11;
        cycle();
        chk("lc_b", lc_data, 8'h62);
        lc_code = 5'd20;
        cycle();
        chk("lc_q", lc_data, 8'h3F);
        chk("lc_valid", lc_avalid, 1);
        lc_tvalid = 1'b0;
        cycle();
        chk("lc_empty", lc_avalid, 0);

        // Fill past capacity, drain in order, clear overflow
        ascii_ready = 1'b0;
        for (int i = 1; i <= 9; i++) begin
            tecla_valid = 1'b1;
            tecla_code  = 5'(i);
            cycle();
            if (i == 8) begin
                chk("fill_full", full, 1);
                chk("fill_ovf0", overflow, 0);
            end
        end
        chk("drop_ovf", overflow, 1);
        chk("drop_count", count, 8);
        tecla_valid = 1'b0;
        ascii_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            chk("drain_data", ascii_data, 8'h31 + 8'(k));
            cycle();
        end
        chk("drain_count", count, 0);
        chk("drain_ovf", overflow, 1);
        overflow_clr = 1'b1;
        cycle();
        overflow_clr = 1'b0;
        chk("clr_ovf", overflow, 0);

        // Full buffer with simultaneous push and pop
        ascii_ready = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tecla_valid = 1'b1;
            tecla_code  = 5'(i);
            cycle();
        end
        chk("pp_full_before", full, 1);
        tecla_code  = 5'd10;
        ascii_ready = 1'b1;
        cycle();
        chk("pp_count", count, 8);
        chk("pp_ovf", overflow, 0);
        tecla_valid = 1'b0;
        last_seen = 8'h00;
        for (int k = 0; k < 8; k++) begin
            last_seen = ascii_data;
            cycle();
        end
        chk("pp_last", last_seen, 8'h41);

        // Reset mid-stream, then first push right after release
        ascii_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tecla_valid = 1'b1;
            tecla_code  = 5'(i + 3);
            cycle();
        end
        tecla_valid = 1'b0;
        do_reset();
        tecla_valid = 1'b1;
        tecla_code  = 5'd7;
        cycle();
        tecla_valid = 1'b0;
        chk("post_rst_valid", ascii_valid, 1);
        chk("post_rst_data", ascii_data, 8'h37);

`ifdef KEY_REPEAT_FILTER_EN
        // Repeat filter window and different-code eligibility
        do_reset();
        ascii_ready = 1'b0;
        start = cyc;
        for (int r = 0; r <= 12; r++) begin
            tecla_valid = (r == 0) || (r == 4) || (r == 12);
            tecla_code  = 5'd5;
            cycle();
        end
        tecla_valid = 1'b0;
        chk("rep_count", count, 2);
        chk("rep_ovf", overflow, 0);
        chk("rep_cycles", cyc - start, 13);
        do_reset();
        tecla_valid = 1'b1;
        tecla_code  = 5'd5;
        cycle();
        tecla_code = 5'd6;
        cycle();
        tecla_valid = 1'b0;
        chk("diff_count", count, 2);
`endif

        // Randomized run against the model
        do_reset();
        for (int n = 0; n < 400; n++) begin
            tecla_valid  = ($urandom_range(0, 99) < 60);
            tecla_code   = $urandom_range(0, 1) ? 5'($urandom_range(0, 3)) : 5'($urandom_range(0, 31));
            ascii_ready  = ($urandom_range(0, 99) < ((n / 100) % 2 == 0 ? 35 : 70));
            overflow_clr = ($urandom_range(0, 99) < 10);
            cycle();
        end
        tecla_valid  = 1'b0;
        overflow_clr = 1'b0;
        ascii_ready  = 1'b1;
        for (int n = 0; n < 10; n++) cycle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
